adc_serial_reader: RTL and testbench
====================================

// Module: adc_serial_reader
// PURPOSE
//  Front end of the pulse-oximetry signal chain. Drives an 8-bit serial ADC (CS_n/SCLK/DOUT).
//  Runs one conversion every SAMPLE_PERIOD clocks and presents each result as a held
//  parallel word ADC_Value, qualified by a 1-cycle Sample_Valid, to the FIR filter input.
//  Same clock domain as the filter. No CDC on outputs. ADC_DOUT is synchronised internally.
// PARAMETERS
//  CLK_DIV        8     system clocks per SCLK half-period; legal range >= 4
//  SETTLE_BITS    1     leading SCLK periods whose DOUT is ignored (ADC mux settle)
//  DATA_BITS      8     data bits per conversion, MSB first; sets ADC_Value width
//  SAMPLE_PERIOD  1024  clocks between conversion starts; must be >= 2*CLK_DIV*(SETTLE_BITS+DATA_BITS)+4
// PORTS
//  CLK_Filter    in   1          system clock, rising edge
//  rst_n         in   1          asynchronous, active-low reset
//  Enable        in   1          high = periodic conversions run
//  ADC_DOUT      in   1          serial data from ADC, asynchronous to CLK_Filter
//  ADC_CS_n      out  1          ADC chip select, active low
//  ADC_SCLK      out  1          ADC serial clock, idles low
//  ADC_Value     out  DATA_BITS  last completed conversion result, held until next result
//  Sample_Valid  out  1          1-cycle pulse when ADC_Value updates
//  Busy          out  1          high while ADC_CS_n is low
// BEHAVIOUR
//  Reset (async assert, sync release): ADC_CS_n=1, ADC_SCLK=0, ADC_Value=0,
//    Sample_Valid=0, Busy=0. FSM is in IDLE. Period counter=0. Synchroniser is cleared.
//  All outputs are registered. ADC_DOUT passes through a 2-flop synchroniser before use.
//  FSM: IDLE -> CONVERT -> DONE -> WAIT -> (CONVERT | IDLE).
//   IDLE: period counter is held at 0. On a clock edge with Enable=1, go to CONVERT.
//     At that edge (T0), ADC_CS_n goes 0 and Busy goes 1.
//   CONVERT: N = SETTLE_BITS+DATA_BITS SCLK periods, k = 0..N-1.
//     SCLK rises at T0 + CLK_DIV*(2k+1) and falls at T0 + CLK_DIV*(2k+2).
//     At each falling edge with k >= SETTLE_BITS, shift the synchronised DOUT into the shift register, MSB first.
//     Bits captured during settle periods are discarded.
//   DONE: one edge after the last fall, at T0 + 2*CLK_DIV*N + 1:
//     - ADC_CS_n=1 and Busy=0
//     - ADC_Value <= shift register
//     - Sample_Valid=1 for exactly that cycle
//     Defaults give: Sample_Valid at T0+145, 9 SCLK pulses.
//   WAIT: the period counter counts cycles since T0.
//     When the counter reaches SAMPLE_PERIOD-1 and Enable=1, the next edge is the new T0 (CONVERT).
//     If Enable=0 at that point, go to IDLE.
//   Conversion spacing is therefore exactly SAMPLE_PERIOD clocks while Enable stays high.
//  Enable falling during CONVERT: the conversion completes normally and produces a result. No further starts.
//  Enable low->high while in WAIT: no effect until the period expires. There is no early start.
//  ADC_Value never changes except at the Sample_Valid cycle. A partial shift is never visible.
//  Reset mid-conversion: ADC_CS_n goes 1 and ADC_SCLK goes 0 immediately. The partial result is discarded.
//    No Sample_Valid is issued. ADC_Value returns to 0.
//  SCLK high and low phases are each exactly CLK_DIV clocks. No glitches on SCLK or CS_n.
// TESTING
//  ADC model: on each SCLK fall k (k = SETTLE_BITS-1 .. N-2), drive data bit DATA_BITS-1-(k-SETTLE_BITS+1).
//  1 Assert rst_n=0 mid-idle -> all outputs hold their reset values. No SCLK activity while Enable=0.
//  2 Enable=1, model word 0xA5 -> CS_n low for 145 clks, 9 SCLK pulses, 8 clks high / 8 clks low,
//    ADC_Value=0xA5, Sample_Valid=1 at T0+145 for one cycle.
//  3 Enable held, model words 0x00, 0xFF, 0x81 -> T0s spaced 1024 clks apart,
//    ADC_Value sequence 0x00, 0xFF, 0x81, exactly one Sample_Valid per conversion.
//  4 Enable dropped at T0+40 with word 0x3C -> 0x3C delivered at T0+145. CS_n stays high afterward. No more SCLK.
//  5 rst_n pulsed low at T0+70 with prior ADC_Value=0x5A -> CS_n=1 and SCLK=0 immediately,
//    ADC_Value=0, no Sample_Valid. Next conversion after release is correct.
//  6 CLK_DIV=4, SAMPLE_PERIOD=100, word 0xC3 -> SCLK 4 high / 4 low,
//    ADC_Value=0xC3 with Sample_Valid at T0+73, next T0 at +100.

Source files
------------

// File: rtl/adc_serial_reader.sv
// Serial ADC front end: periodically clocks one conversion out of an 8-bit SPI-style ADC
// and presents the result as a held parallel word with a one-cycle valid strobe.
//
// state      | meaning
// ST_IDLE    | no conversion running, period counter held at 0, waiting for Enable
// ST_CONVERT | CS_n low, SCLK toggling every CLK_DIV clocks, bits shifted on falls
// ST_DONE    | release CS_n, publish shift register, pulse Sample_Valid
// ST_WAIT    | CS_n high, period counter runs until the next conversion slot
module adc_serial_reader #(
   parameter int CLK_DIV       = 8,
   parameter int SETTLE_BITS   = 1,
   parameter int DATA_BITS     = 8,
   parameter int SAMPLE_PERIOD = 1024
) (
   input  logic                 CLK_Filter,
   input  logic                 rst_n,
   input  logic                 Enable,
   input  logic                 ADC_DOUT,
   output logic                 ADC_CS_n,
   output logic                 ADC_SCLK,
   output logic [DATA_BITS-1:0] ADC_Value,
   output logic                 Sample_Valid,
   output logic                 Busy
);

   localparam int N     = SETTLE_BITS + DATA_BITS;
   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int BIT_W = $clog2(N + 1);
   localparam int PER_W = $clog2(SAMPLE_PERIOD);

   localparam logic [DIV_W-1:0] DIV_LOAD   = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(N - 1);
   localparam logic [BIT_W-1:0] BIT_SETTLE = BIT_W'(SETTLE_BITS);
   localparam logic [PER_W-1:0] PER_LAST   = PER_W'(SAMPLE_PERIOD - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_DONE    = 2'd2,
      ST_WAIT    = 2'd3
   } state_t;

   state_t               state;
   logic                 dout_meta;
   logic                 dout_sync;
   logic [DIV_W-1:0]     div_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [PER_W-1:0]     period_cnt;
   logic [DATA_BITS-1:0] shift_reg;

   always_ff @(posedge CLK_Filter or negedge rst_n) begin
      if (!rst_n) begin
         dout_meta <= 1'b0;
         dout_sync <= 1'b0;
      end else begin
         dout_meta <= ADC_DOUT;
         dout_sync <= dout_meta;
      end
   end

   always_ff @(posedge CLK_Filter or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         ADC_CS_n     <= 1'b1;
         ADC_SCLK     <= 1'b0;
         ADC_Value    <= '0;
         Sample_Valid <= 1'b0;
         Busy         <= 1'b0;
         div_cnt      <= '0;
         bit_cnt      <= '0;
         period_cnt   <= '0;
         shift_reg    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               period_cnt   <= '0;
               Sample_Valid <= 1'b0;
               if (Enable) begin
                  state     <= ST_CONVERT;
                  ADC_CS_n  <= 1'b0;
                  Busy      <= 1'b1;
                  div_cnt   <= DIV_LOAD;
                  bit_cnt   <= '0;
                  shift_reg <= '0;
               end
            end

            ST_CONVERT: begin
               period_cnt <= period_cnt + PER_W'(1);
               if (div_cnt == '0) begin
                  div_cnt  <= DIV_LOAD;
                  ADC_SCLK <= ~ADC_SCLK;
                  // Falling edge: sample DOUT that the ADC launched on the previous fall
                  if (ADC_SCLK) begin
                     if (bit_cnt >= BIT_SETTLE)
                        shift_reg <= {shift_reg[DATA_BITS-2:0], dout_sync};
                     if (bit_cnt == BIT_LAST)
                        state <= ST_DONE;
                     else
                        bit_cnt <= bit_cnt + BIT_W'(1);
                  end
               end else begin
                  div_cnt <= div_cnt - DIV_W'(1);
               end
            end

            ST_DONE: begin
               period_cnt   <= period_cnt + PER_W'(1);
               ADC_CS_n     <= 1'b1;
               Busy         <= 1'b0;
               ADC_Value    <= shift_reg;
               Sample_Valid <= 1'b1;
               state        <= ST_WAIT;
            end

            ST_WAIT: begin
               Sample_Valid <= 1'b0;
               if (period_cnt == PER_LAST) begin
                  period_cnt <= '0;
                  if (Enable) begin
                     state     <= ST_CONVERT;
                     ADC_CS_n  <= 1'b0;
                     Busy      <= 1'b1;
                     div_cnt   <= DIV_LOAD;
                     bit_cnt   <= '0;
                     shift_reg <= '0;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  period_cnt <= period_cnt + PER_W'(1);
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_serial_reader.sv
// Bench for adc_serial_reader: default instance plus a fast CLK_DIV=4 / SAMPLE_PERIOD=100 one,
// each with a behavioural ADC model and a monitor that checks timing and scoreboarded results.
module tb_adc_serial_reader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       en [2] = '{1'b0, 1'b0};
   logic       dout [2] = '{1'b0, 1'b0};
   logic       csn [2];
   logic       sclk [2];
   logic       valid [2];
   logic       busy [2];
   logic [7:0] value [2];

   always #5 clk = ~clk;

   adc_serial_reader dut0 (
      .CLK_Filter(clk), .rst_n(rst_n), .Enable(en[0]), .ADC_DOUT(dout[0]),
      .ADC_CS_n(csn[0]), .ADC_SCLK(sclk[0]), .ADC_Value(value[0]),
      .Sample_Valid(valid[0]), .Busy(busy[0])
   );

   adc_serial_reader #(.CLK_DIV(4), .SETTLE_BITS(1), .DATA_BITS(8), .SAMPLE_PERIOD(100)) dut1 (
      .CLK_Filter(clk), .rst_n(rst_n), .Enable(en[1]), .ADC_DOUT(dout[1]),
      .ADC_CS_n(csn[1]), .ADC_SCLK(sclk[1]), .ADC_Value(value[1]),
      .Sample_Valid(valid[1]), .Busy(busy[1])
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;

   function automatic void chk(string name, int act, int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, expv, cyc);
      end
   endfunction

   always @(posedge clk) cyc++;

   // ADC model: after fall k drives data bit 7-k (k = 0..7), settle fall k=0 launches the MSB
   logic [7:0] word [2];
   int         kf [2] = '{0, 0};

   always @(negedge csn[0]) kf[0] = 0;
   always @(negedge csn[1]) kf[1] = 0;
   always @(negedge sclk[0]) begin
      if (kf[0] <= 7) dout[0] = word[0][7-kf[0]];
      kf[0]++;
   end
   always @(negedge sclk[1]) begin
      if (kf[1] <= 7) dout[1] = word[1][7-kf[1]];
      kf[1]++;
   end

   logic [7:0] q0 [$];
   logic [7:0] q1 [$];

   int         div_c [2] = '{8, 4};
   int         len_c [2] = '{145, 73};
   int         run [2] = '{0, 0};
   int         pulses [2] = '{0, 0};
   int         t0 [2] = '{0, 0};
   int         nfalls [2] = '{0, 0};
   int         nvalid [2] = '{0, 0};
   logic       prev_cs [2] = '{1'b1, 1'b1};
   logic       prev_sclk [2] = '{1'b0, 1'b0};
   logic       prev_valid [2] = '{1'b0, 1'b0};
   logic [7:0] prev_value [2] = '{8'h00, 8'h00};

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            chk("rst_cs_n", csn[i], 1);
            chk("rst_sclk", sclk[i], 0);
            chk("rst_value", value[i], 0);
            chk("rst_valid", valid[i], 0);
            chk("rst_busy", busy[i], 0);
            prev_cs[i] = 1'b1;
            prev_sclk[i] = 1'b0;
            prev_valid[i] = 1'b0;
            prev_value[i] = 8'h00;
            run[i] = 0;
         end else begin
            if (prev_cs[i] && !csn[i]) begin
               t0[i] = cyc;
               nfalls[i]++;
               pulses[i] = 0;
               run[i] = 0;
            end
            if (!prev_cs[i] && csn[i]) begin
               chk("cs_low_len", cyc - t0[i], len_c[i]);
               chk("sclk_pulses", pulses[i], 9);
            end
            if (sclk[i] != prev_sclk[i]) begin
               if (sclk[i]) begin
                  chk("sclk_low_len", run[i], div_c[i]);
                  pulses[i]++;
               end else begin
                  chk("sclk_high_len", run[i], div_c[i]);
               end
               run[i] = 1;
            end else begin
               run[i]++;
            end
            if (csn[i]) chk("sclk_idle", sclk[i], 0);
            chk("busy", busy[i], !csn[i]);
            if (valid[i]) begin
               nvalid[i]++;
               chk("valid_width", prev_valid[i], 0);
               chk("valid_time", cyc - t0[i], len_c[i]);
               if (i == 0) begin
                  if (q0.size() == 0) chk("unexpected_valid0", 0, 1);
                  else chk("value0", value[i], q0.pop_front());
               end else begin
                  if (q1.size() == 0) chk("unexpected_valid1", 0, 1);
                  else chk("value1", value[i], q1.pop_front());
               end
            end else begin
               chk("value_hold", value[i], prev_value[i]);
            end
            prev_cs[i] = csn[i];
            prev_sclk[i] = sclk[i];
            prev_valid[i] = valid[i];
            prev_value[i] = value[i];
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int i, input int lim, input string name);
      int n = 0;
      while (!valid[i] && n < lim) begin
         cycles(1);
         n++;
      end
      chk(name, n < lim, 1);
      cycles(1);
   endtask

   task automatic wait_cs_fall(input int i, input int lim, input string name);
      int n = 0;
      while (csn[i] && n < lim) begin
         cycles(1);
         n++;
      end
      chk(name, n < lim, 1);
   endtask

   typedef struct {
      logic [7:0] word;
      logic [7:0] exp_value;
      int         exp_gap;
   } vec_t;

   initial begin
      vec_t tbl [4];
      int   prev_t0;
      int   nv;
      int   f;

      tbl[0] = '{8'hA5, 8'hA5, 0};
      tbl[1] = '{8'h00, 8'h00, 1024};
      tbl[2] = '{8'hFF, 8'hFF, 1024};
      tbl[3] = '{8'h81, 8'h81, 1024};
      word[0] = 8'h00;
      word[1] = 8'h00;

      #2 rst_n = 1'b0;
      cycles(3);
      rst_n = 1'b1;
      cycles(20);

      // reset asserted while idle, then idle with Enable low
      rst_n = 1'b0;
      #1;
      chk("t1_cs_n", csn[0], 1);
      chk("t1_sclk", sclk[0], 0);
      chk("t1_value", value[0], 0);
      cycles(3);
      rst_n = 1'b1;
      cycles(50);
      chk("t1_no_start0", nfalls[0], 0);
      chk("t1_no_start1", nfalls[1], 0);

      // single conversion then back-to-back conversions with Enable held
      nv = nvalid[0];
      prev_t0 = 0;
      for (int j = 0; j < 4; j++) begin
         word[0] = tbl[j].word;
         q0.push_back(tbl[j].exp_value);
         if (j == 0) en[0] = 1'b1;
         wait_valid(0, 1200, "t23_valid_timeout");
         chk("t23_value", value[0], tbl[j].exp_value);
         if (tbl[j].exp_gap != 0) chk("t3_spacing", t0[0] - prev_t0, tbl[j].exp_gap);
         prev_t0 = t0[0];
      end
      chk("t3_valid_count", nvalid[0] - nv, 4);

      // Enable dropped mid-conversion
      word[0] = 8'h3C;
      q0.push_back(8'h3C);
      wait_cs_fall(0, 1100, "t4_start_timeout");
      cycles(39);
      en[0] = 1'b0;
      wait_valid(0, 200, "t4_valid_timeout");
      chk("t4_value", value[0], 8'h3C);
      f = nfalls[0];
      cycles(1500);
      chk("t4_no_restart", nfalls[0], f);
      chk("t4_cs_high", csn[0], 1);

      // reset in the middle of a conversion
      word[0] = 8'h5A;
      q0.push_back(8'h5A);
      en[0] = 1'b1;
      wait_valid(0, 300, "t5_prior_timeout");
      chk("t5_prior", value[0], 8'h5A);
      word[0] = 8'h96;
      q0.push_back(8'h96);
      wait_cs_fall(0, 1100, "t5_start_timeout");
      cycles(69);
      rst_n = 1'b0;
      #1;
      chk("t5_cs_n", csn[0], 1);
      chk("t5_sclk", sclk[0], 0);
      chk("t5_value", value[0], 0);
      chk("t5_valid", valid[0], 0);
      q0.delete();
      word[0] = 8'h69;
      q0.push_back(8'h69);
      cycles(3);
      rst_n = 1'b1;
      wait_valid(0, 300, "t5_after_timeout");
      chk("t5_after", value[0], 8'h69);
      en[0] = 1'b0;
      cycles(1100);

      // fast instance
      word[1] = 8'hC3;
      q1.push_back(8'hC3);
      en[1] = 1'b1;
      wait_valid(1, 200, "t6_valid_timeout");
      chk("t6_value", value[1], 8'hC3);
      prev_t0 = t0[1];
      word[1] = 8'h24;
      q1.push_back(8'h24);
      wait_valid(1, 200, "t6_second_timeout");
      chk("t6_second", value[1], 8'h24);
      chk("t6_spacing", t0[1] - prev_t0, 100);
      en[1] = 1'b0;
      cycles(200);
      chk("t6_queue_empty", q0.size() + q1.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
